// File: rtl/led_seq_ctrl_if.sv
// Switch/LED signal bundle for led_seq_ctrl: the board-switch side drives the
// inputs (master), the sequencer drives the LED and status outputs (slave).
interface led_seq_ctrl_if #(
  parameter int NB_LEDS = 4
);
  logic               i_enable;
  logic [1:0]         i_speed;
  logic               i_color;
  logic [NB_LEDS-1:0] o_led;
  logic [NB_LEDS-1:0] o_led_b;
  logic [NB_LEDS-1:0] o_led_g;
  logic               o_tick;
  logic [1:0]         o_state;

  modport master (
    output i_enable, i_speed, i_color,
    input  o_led, o_led_b, o_led_g, o_tick, o_state
  );

  modport slave (
    input  i_enable, i_speed, i_color,
    output o_led, o_led_b, o_led_g, o_tick, o_state
  );
endinterface

// File: rtl/led_seq_ctrl.sv
// LED bank sequencer: prescaled tick drives a shift-left / shift-right / flash
// pattern FSM, routed to the blue or green group. Macro LED_SEQ_FLASH_EN enables FLASH.
module led_seq_ctrl #(
  parameter int NB_LEDS     = 4,
  parameter int NB_COUNTER  = 16,
  parameter int LIMIT_R0    = 100,
  parameter int LIMIT_R1    = 200,
  parameter int LIMIT_R2    = 400,
  parameter int LIMIT_R3    = 800,
  parameter int FLASH_TICKS = 4
) (
  input  logic          clock,
  input  logic          i_reset,
  led_seq_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHL   = 2'd1;
  localparam logic [1:0] ST_SHR   = 2'd2;
  localparam logic [1:0] ST_FLASH = 2'd3;

  localparam int FCW = $clog2(FLASH_TICKS);
  localparam logic [FCW-1:0]     FLASH_LAST = FCW'(FLASH_TICKS - 1);
  localparam logic [NB_LEDS-1:0] PAT_ONE    = NB_LEDS'(1);
  localparam logic [NB_LEDS-1:0] PAT_ALL    = '1;

  logic [1:0]            state;
  logic [NB_LEDS-1:0]    pattern;
  logic [NB_COUNTER-1:0] cnt;
  logic [NB_COUNTER-1:0] limit;
  logic [FCW-1:0]        flash_cnt;
  logic                  color_q;
  logic                  tick;

  always_comb begin
    limit = NB_COUNTER'(LIMIT_R0);
    case (bus.i_speed)
      2'd1:    limit = NB_COUNTER'(LIMIT_R1);
      2'd2:    limit = NB_COUNTER'(LIMIT_R2);
      2'd3:    limit = NB_COUNTER'(LIMIT_R3);
      default: limit = NB_COUNTER'(LIMIT_R0);
    endcase
  end

  // >= rather than == so a speed drop below the running count ticks at once
  assign tick = bus.i_enable && (state != ST_IDLE) && (cnt >= limit);

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      pattern   <= '0;
      cnt       <= '0;
      flash_cnt <= '0;
      color_q   <= 1'b0;
    end else begin
      if (state == ST_IDLE || tick) begin
        cnt <= '0;
      end else if (bus.i_enable) begin
        cnt <= cnt + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          color_q <= bus.i_color;
          if (bus.i_enable) begin
            state   <= ST_SHL;
            pattern <= PAT_ONE;
          end
        end
        ST_SHL: begin
          if (tick) begin
            if (pattern[NB_LEDS-1]) begin
              state   <= ST_SHR;
              pattern <= pattern >> 1;
            end else begin
              pattern <= pattern << 1;
            end
          end
        end
        ST_SHR: begin
          if (tick) begin
            if (pattern[0]) begin
`ifdef LED_SEQ_FLASH_EN
              state     <= ST_FLASH;
              pattern   <= PAT_ALL;
              flash_cnt <= '0;
`else
              // Sequence boundary without FLASH: restart and take the new colour
              state   <= ST_SHL;
              pattern <= PAT_ONE;
              color_q <= bus.i_color;
`endif
            end else begin
              pattern <= pattern >> 1;
            end
          end
        end
        ST_FLASH: begin
          if (tick) begin
            if (flash_cnt == FLASH_LAST) begin
              state     <= ST_SHL;
              pattern   <= PAT_ONE;
              flash_cnt <= '0;
              color_q   <= bus.i_color;
            end else begin
              pattern   <= ~pattern;
              flash_cnt <= flash_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_led   = pattern;
  assign bus.o_led_b = color_q ? '0 : pattern;
  assign bus.o_led_g = color_q ? pattern : '0;
  assign bus.o_tick  = tick;
  assign bus.o_state = state;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl: reset, sequence, speed change, colour
// boundary, freeze and reset-in-sequence, for both LED_SEQ_FLASH_EN builds.
module tb_led_seq_ctrl;
  localparam int NB_LEDS = 4;

`ifdef LED_SEQ_FLASH_EN
  localparam int N = 11;
  localparam int RESET_POS = 7;
  logic [3:0] seq_pat [0:10] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010,
                                 4'b0001, 4'b1111, 4'b0000, 4'b1111, 4'b0000};
  logic [1:0] seq_st  [0:10] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2,
                                 2'd3, 2'd3, 2'd3, 2'd3};
`else
  localparam int N = 7;
  localparam int RESET_POS = 4;
  logic [3:0] seq_pat [0:10] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010,
                                 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
  logic [1:0] seq_st  [0:10] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2,
                                 2'd0, 2'd0, 2'd0, 2'd0};
`endif

  logic clock = 1'b0;
  logic i_reset;
  int   checks = 0;
  int   failures = 0;
  int   p = 0;
  logic exp_col = 1'b0;
  logic seen3 = 1'b0;

  always #5 clock = ~clock;

  led_seq_ctrl_if #(.NB_LEDS(NB_LEDS)) bus ();

  led_seq_ctrl #(.NB_LEDS(NB_LEDS)) dut (
    .clock   (clock),
    .i_reset (i_reset),
    .bus     (bus.slave)
  );

  task automatic step();
    @(posedge clock);
    #1;
    if (bus.o_state == 2'd3) seen3 = 1'b1;
  endtask

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_led"},   32'(bus.o_led),   32'(seq_pat[p]));
    chk({tag, "_led_b"}, 32'(bus.o_led_b), 32'(exp_col ? 4'd0 : seq_pat[p]));
    chk({tag, "_led_g"}, 32'(bus.o_led_g), 32'(exp_col ? seq_pat[p] : 4'd0));
    chk({tag, "_state"}, 32'(bus.o_state), 32'(seq_st[p]));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_led"},   32'(bus.o_led),   0);
    chk({tag, "_led_b"}, 32'(bus.o_led_b), 0);
    chk({tag, "_led_g"}, 32'(bus.o_led_g), 0);
    chk({tag, "_state"}, 32'(bus.o_state), 0);
    chk({tag, "_tick"},  32'(bus.o_tick),  0);
  endtask

  // Cycles waited before o_tick is seen; the cycle that consumes the tick is
  // the extra one, so a gap of LIMIT means a tick period of LIMIT+1 cycles.
  task automatic do_tick(input int gap, input string tag);
    int n;
    n = 0;
    while (bus.o_tick !== 1'b1 && n < 3000) begin
      step();
      n++;
    end
    chk({tag, "_gap"}, n, gap);
    step();
    p = (p + 1) % N;
    if (p == 0) exp_col = bus.i_color;
    check_outputs(tag);
  endtask

  initial begin
    int tk;
    i_reset      = 1'b1;
    bus.i_enable = 1'b1;
    bus.i_speed  = 2'd0;
    bus.i_color  = 1'b0;

    // Reset held with enable asserted
    for (int i = 0; i < 10; i++) begin
      step();
      check_zero("reset");
    end

    // Release: IDLE -> SHL with pattern 0001 on the first edge
    i_reset = 1'b0;
    step();
    p = 0;
    exp_col = 1'b0;
    check_outputs("enter_shl");
    chk("enter_shl_tick", 32'(bus.o_tick), 0);

    // Full sequence at speed 0, blue
    do_tick(100, "seq_first");
    for (int i = 1; i < N; i++) do_tick(100, "seq");

    // Speed 0 -> 3 mid-count (cnt=50), then 3 -> 0 with cnt=300
    repeat (50) step();
    bus.i_speed = 2'd3;
    do_tick(750, "spd3_first");
    do_tick(800, "spd3_full");
    repeat (300) step();
    bus.i_speed = 2'd0;
    #1;
    chk("spd0_immediate_tick", 32'(bus.o_tick), 1);
    step();
    p = (p + 1) % N;
    check_outputs("spd0_immediate");
    do_tick(100, "spd0_after");

    // Colour change mid-sequence takes effect only at the boundary
    while (p != 0) do_tick(100, "to_boundary");
    do_tick(100, "pre_color");
    do_tick(100, "pre_color");
    bus.i_color = 1'b1;
    while (p != 0) do_tick(100, "color_hold");
    chk("color_boundary_g", 32'(bus.o_led_g), 32'h1);
    chk("color_boundary_b", 32'(bus.o_led_b), 32'h0);

    // Freeze at pattern 0010 with cnt=20, then resume for the remaining 80
    do_tick(100, "pre_freeze");
    repeat (20) step();
    bus.i_enable = 1'b0;
    tk = 0;
    repeat (50) begin
      step();
      if (bus.o_tick === 1'b1) tk++;
    end
    chk("frozen_ticks", tk, 0);
    check_outputs("frozen");
    bus.i_enable = 1'b1;
    do_tick(80, "resume");

    // Reset in the middle of the sequence (FLASH when present, else SHR)
    while (p != RESET_POS) do_tick(100, "to_reset_pos");
    repeat (10) step();
    i_reset = 1'b1;
    step();
    check_zero("mid_reset");
    i_reset = 1'b0;
    bus.i_color = 1'b0;
    step();
    p = 0;
    exp_col = 1'b0;
    check_outputs("restart");

`ifdef LED_SEQ_FLASH_EN
    chk("flash_state_seen", 32'(seen3), 1);
`else
    chk("flash_state_absent", 32'(seen3), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
- Sequencer for the LED bank: a prescaled tick drives a pattern state machine (shift left, shift right, flash) and routes the pattern to the blue or green LED group.
- Sits between the board switches (enable, speed, colour) and the LED pins, replacing the bare counter-to-LED path.
- Colour changes take effect only at sequence boundaries, never mid-sequence.

Parameters:
NB_LEDS, 4, LED bank width (>=2)
NB_COUNTER, 16, prescaler counter width
LIMIT_R0, 100, prescaler limit for speed 0; tick every LIMIT+1 enabled cycles
LIMIT_R1, 200, prescaler limit for speed 1
LIMIT_R2, 400, prescaler limit for speed 2
LIMIT_R3, 800, prescaler limit for speed 3
FLASH_TICKS, 4, ticks spent in FLASH state (>=2, even)

Ports:
clock  input  1  system clock, rising edge
i_reset  input  1  synchronous reset, active-high
i_enable  input  1  run (1) / freeze (0)
i_speed  input  2  speed select R0..R3
i_color  input  1  0 = blue, 1 = green
o_led  output  NB_LEDS  current pattern
o_led_b  output  NB_LEDS  pattern when latched colour is blue, else 0
o_led_g  output  NB_LEDS  pattern when latched colour is green, else 0
o_tick  output  1  prescaler tick (one-cycle pulse)
o_state  output  2  FSM state: IDLE=0, SHL=1, SHR=2, FLASH=3

Behaviour:
- Reset (synchronous, active-high, wins over everything):
  - next edge: state=IDLE, pattern=0, prescaler count=0, flash count=0, colour latch=0.
  - Hence o_led, o_led_b and o_led_g are 0, o_tick=0 and o_state=0.
- Prescaler:
  - limit = LIMIT_R[i_speed], sampled every cycle.
  - tick = i_enable && state!=IDLE && cnt>=limit (combinational); o_tick=tick.
  - On tick, cnt<=0; else if i_enable and not IDLE, cnt<=cnt+1; else cnt holds.
  - IDLE forces cnt<=0.
  - A speed change to a limit below the current cnt ticks on the next enabled cycle.
- IDLE:
  - Colour latch <= i_color every cycle.
  - If i_enable=1: state<=SHL, pattern<=1 (LSB set).
- SHL, on tick:
  - If pattern MSB set: state<=SHR, pattern<=pattern>>1.
  - Else pattern<=pattern<<1.
- SHR, on tick:
  - If pattern LSB set: state<=FLASH, pattern<=all-ones, flash count<=0.
  - Else pattern<=pattern>>1.
- FLASH, on tick:
  - If flash count==FLASH_TICKS-1: state<=SHL, pattern<=1, flash count<=0, colour latch<=i_color.
  - Else pattern<=~pattern, flash count++.
- No tick: state and pattern hold.
- i_enable=0 outside IDLE freezes state, pattern, cnt and colour; no return to IDLE.
- Sequence for NB_LEDS=4, FLASH_TICKS=4, one pattern per tick period:
  - 0001, 0010, 0100, 1000, 0100, 0010, 0001, 1111, 0000, 1111, 0000, then back to 0001.
  - Full sequence period is 11 ticks.
- Outputs:
  - o_led = pattern (registered).
  - o_led_b = colour latch ? 0 : pattern.
  - o_led_g = colour latch ? pattern : 0.
  - Exactly one group is nonzero at any time. Toggling i_color mid-sequence changes nothing until the boundary tick.

Optional Feature:
LED_SEQ_FLASH_EN
- Defined: FLASH state is present, as above.
- Undefined:
  - FLASH is never entered; o_state never reads 3.
  - The SHR tick with LSB set goes to SHL with pattern held at 1 and latches colour.
  - Period becomes 7 ticks for NB_LEDS=4: 0001, 0010, 0100, 1000, 0100, 0010, 0001, then 0001 again.
  - FLASH_TICKS is unused.

Test Plan:
1. Reset held 10 cycles with i_enable=1 -> o_led=0, o_led_b=0, o_led_g=0, o_state=0, o_tick never high.
2. Release reset; i_enable=1, speed 0, colour 0 -> first o_tick 101 cycles after entering SHL. Ticks thereafter every 101 cycles (1010 ns at 10 ns clock). o_led_b follows the 11-tick sequence above; o_led_g stays 0.
3. Speed 0 to 3 mid-count, then 3 to 0 with cnt=300 -> tick spacing becomes 801 cycles; on the switch back, tick on the next cycle, then every 101 cycles.
4. Set i_color=1 while pattern=0100 in SHL -> o_led_b keeps the pattern through SHR and FLASH. At the FLASH-exit tick, o_led_g=0001 and o_led_b=0.
5. Drop i_enable for 50 cycles at pattern 0010 -> pattern, o_state and cnt frozen, no o_tick. On re-enable, the next tick arrives after the remaining count.
6. Apply reset in FLASH, and separately build without LED_SEQ_FLASH_EN -> reset gives all outputs 0 and state IDLE on the next edge. Without the macro, the period is 7 ticks and o_state never equals 3.
